// File: rtl/fuzz_pipe_pkg.sv
// Shared types, default parameters and the signature update function for fuzz_pipe.
package fuzz_pipe_pkg;

    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned DEF_LW     = 24;
    localparam int unsigned DEF_STAGES = 2;
    localparam int unsigned DEF_SIG_W  = 8;
    localparam int unsigned SIG_MAX    = 32;

    typedef struct packed {
        logic [1:0] c2;
        logic       c3;
    } lane_res_t;

    // Rotate-left by one within the low w bits, then fold in {c2, c3}.
    function automatic logic [SIG_MAX-1:0] sig_next(input logic [SIG_MAX-1:0] sig,
                                                    input lane_res_t         res,
                                                    input int unsigned       w);
        logic [SIG_MAX-1:0] mask;
        logic [SIG_MAX-1:0] rot;
        mask = (w >= SIG_MAX) ? '1 : ((SIG_MAX'(1) << w) - SIG_MAX'(1));
        rot  = ((sig << 1) | (sig >> (w - 1))) & mask;
        return rot ^ (SIG_MAX'({res.c2, res.c3}) & mask);
    endfunction

endpackage

// File: rtl/fuzz_pipe_lane.sv
// Combinational cell network for one lane: slice -> {c2, c3}.
module fuzz_pipe_lane
    import fuzz_pipe_pkg::*;
#(
    parameter int unsigned LW = DEF_LW
) (
    input  logic [LW-1:0] slice,
    output lane_res_t     res_c
);

    logic       c0;
    logic [1:0] c1;
    logic       unused_hi;

    assign unused_hi = ^slice[LW-1:6];

    always_comb begin
        res_c    = '0;
        c0       = slice[1] | slice[5];
        c1       = 2'({c0, c0} * {c0, c0});
        res_c.c2 = c1[0] ? slice[3:2] : {c1[0], c0};
        res_c.c3 = slice[3] ? res_c.c2[0] : res_c.c2[1];
    end

endmodule

// File: rtl/fuzz_pipe_top.sv
// Multi-lane cell pipeline with bubble-collapsing valid/ready stages,
// per-lane output signatures and a saturating output transfer counter.
module fuzz_pipe_top
    import fuzz_pipe_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned LW     = DEF_LW,
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned SIG_W  = DEF_SIG_W
) (
    input  logic                   clkin_data,
    input  logic                   rst_n,
    input  logic [LANES*LW-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LANES*3-1:0]     out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*SIG_W-1:0] sig_data,
    output logic [15:0]            txn_count
);

    if (LW < 8) begin : g_bad_lw
        $error("fuzz_pipe_top: LW must be at least 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("fuzz_pipe_top: STAGES must be 1..4");
    end
    if (SIG_W < 1 || SIG_W > SIG_MAX) begin : g_bad_sig_w
        $error("fuzz_pipe_top: SIG_W out of range");
    end

    lane_res_t [LANES-1:0]             in_res_c;
    lane_res_t [LANES-1:0]             stage_q [STAGES];
    lane_res_t [LANES-1:0]             head;
    logic      [STAGES-1:0]            vld_q;
    logic      [STAGES-1:0]            rdy_c;
    logic      [LANES-1:0][SIG_W-1:0]  sig_q;
    logic      [15:0]                  txn_q;
    logic                              out_fire;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fuzz_pipe_lane #(.LW(LW)) u_lane (
            .slice (in_data[l*LW +: LW]),
            .res_c (in_res_c[l])
        );
    end

    // A stage may load when it or any stage below it is empty, or the consumer takes the head.
    always_comb begin
        rdy_c = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            rdy_c[i] = out_ready;
            for (int unsigned j = i; j < STAGES; j++) begin
                if (!vld_q[j]) begin
                    rdy_c[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready  = rdy_c[0];
    assign head      = stage_q[STAGES-1];
    assign out_valid = vld_q[STAGES-1];
    assign out_fire  = out_valid & out_ready;
    assign sig_data  = sig_q;
    assign txn_count = txn_q;

    always_ff @(posedge clkin_data or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            if (rdy_c[0]) begin
                vld_q[0]   <= in_valid;
                stage_q[0] <= in_res_c;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (rdy_c[i]) begin
                    vld_q[i]   <= vld_q[i-1];
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            out_data[l]               = head[l].c3;
            out_data[LANES+2*l +: 2]  = head[l].c2;
        end
    end

    always_ff @(posedge clkin_data or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
            txn_q <= '0;
        end else if (out_fire) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                sig_q[l] <= SIG_W'(sig_next(SIG_MAX'(sig_q[l]), head[l], SIG_W));
            end
            if (txn_q != 16'hFFFF) begin
                txn_q <= txn_q + 16'd1;
            end
        end
    end

endmodule
